// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit:
// opcodes, FSM state codes and datapath mux select values.
package controller_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Codes 11..15 are unused and fall back to Fetch.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE_R = 4'd6,
    S_EXECUTE_I = 4'd7,
    S_JAL       = 4'd8,
    S_ALUWB     = 4'd9,
    S_BEQ       = 4'd10
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMMEXT = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Combinational immediate-format decode from the instruction opcode.
module instr_decoder
  import controller_pkg::*;
#(
  parameter int OpcodeWidth = 7
) (
  input  logic [OpcodeWidth-1:0] Opcode,
  output logic [1:0]             ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (Opcode)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_controller.sv
// Multicycle main control FSM: sequences one instruction over 2-5 cycles and
// drives every datapath mux select and architectural write enable.
module main_controller
  import controller_pkg::*;
#(
  parameter int OpcodeWidth = 7
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [OpcodeWidth-1:0] Opcode,
  input  logic                   Zero,
  output logic                   PCWrite,
  output logic                   AdrSrc,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic [1:0]             ResultSrc,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             ImmSrc,
  output logic [3:0]             State
);

  state_t state_reg, state_next;
  logic   pc_update, branch;

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ALUOp      = ALUOP_ADD;

    case (state_reg)
      S_FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        pc_update  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMMEXT;
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTE_R;
          OP_I_ALU:     state_next = S_EXECUTE_I;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMMEXT;
        state_next = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE_R: begin
        ALUSrcA    = SRCA_RD1;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTE_I: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMMEXT;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset aborts the current instruction: no enable may fire and the
    // selects already present the Fetch configuration.
    if (RST) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      ResultSrc = RES_ALURESULT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ALUOp     = ALUOP_ADD;
    end

    PCWrite = pc_update | (branch & Zero);
  end

  instr_decoder #(.OpcodeWidth(OpcodeWidth)) u_instr_decoder (
    .Opcode (Opcode),
    .ImmSrc (ImmSrc)
  );

  assign State = state_reg;

endmodule

// File: tb/tb_main_controller.sv
// Randomized self-checking bench: each instruction is expanded into the
// expected per-cycle control vector list and compared cycle by cycle.
module tb_main_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] Opcode;
  logic       Zero;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;

  main_controller #(.OpcodeWidth(7)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Opcode    (Opcode),
    .Zero      (Zero),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .State     (State)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       st;
    bit       pcw, irw, rgw, mw, adr;
    bit [1:0] res, sa, sb, aop;
    bit       imm_chk;
    bit       is_beq;
  } step_t;

  step_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic step_t mk(input int st, input bit pcw, input bit irw, input bit rgw,
                               input bit mw, input bit adr, input bit [1:0] res,
                               input bit [1:0] sa, input bit [1:0] sb, input bit [1:0] aop);
    step_t s;
    s.st = st; s.pcw = pcw; s.irw = irw; s.rgw = rgw; s.mw = mw; s.adr = adr;
    s.res = res; s.sa = sa; s.sb = sb; s.aop = aop;
    s.imm_chk = (st == 1 || st == 2);
    s.is_beq  = (st == 10);
    return s;
  endfunction

  function automatic bit [1:0] exp_imm(input logic [6:0] op);
    case (op)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // Control vectors straight from the state table, chained per instruction class.
  function automatic void build(input logic [6:0] op);
    exp_q.delete();
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0));
    case (op)
      7'b0000011: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0));
        exp_q.push_back(mk(3, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0));
        exp_q.push_back(mk(4, 0, 0, 1, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0));
      end
      7'b0100011: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0));
        exp_q.push_back(mk(5, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0));
      end
      7'b0110011: begin
        exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2));
        exp_q.push_back(mk(9, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0));
      end
      7'b0010011: begin
        exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd2));
        exp_q.push_back(mk(9, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0));
      end
      7'b1101111: begin
        exp_q.push_back(mk(8, 1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0));
        exp_q.push_back(mk(9, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0));
      end
      7'b1100011:
        exp_q.push_back(mk(10, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1));
      default: ;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pcwrite"},  PCWrite,   0);
    check({tag, "_irwrite"},  IRWrite,   0);
    check({tag, "_regwrite"}, RegWrite,  0);
    check({tag, "_memwrite"}, MemWrite,  0);
    check({tag, "_alusrcb"},  ALUSrcB,   2);
    check({tag, "_resultsrc"}, ResultSrc, 2);
  endtask

  // zmode: 0/1 force Zero, 2 random. Returns after the edge ending the instruction.
  task automatic run_instr(input logic [6:0] op, input int zmode, input bit allow_rst);
    step_t s;
    bit    rst_now;
    bit    aborted = 0;
    int    cycles  = 0;
    build(op);
    for (int i = 0; i < exp_q.size(); i++) begin
      s       = exp_q[i];
      Opcode  = s.imm_chk ? op : 7'($urandom);
      Zero    = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      rst_now = allow_rst && ($urandom_range(0, 15) == 0);
      RST     = rst_now;
      @(negedge CLK);
      cycles++;
      check("state", State, s.st);
      if (rst_now) begin
        check_reset_outputs("rst_mid");
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rst_state", State, 0);
        aborted = 1;
        break;
      end
      check("pcwrite",   PCWrite,   s.is_beq ? Zero : s.pcw);
      check("irwrite",   IRWrite,   s.irw);
      check("regwrite",  RegWrite,  s.rgw);
      check("memwrite",  MemWrite,  s.mw);
      check("adrsrc",    AdrSrc,    s.adr);
      check("resultsrc", ResultSrc, s.res);
      check("alusrca",   ALUSrcA,   s.sa);
      check("alusrcb",   ALUSrcB,   s.sb);
      check("aluop",     ALUOp,     s.aop);
      if (s.imm_chk) check("immsrc", ImmSrc, exp_imm(op));
      @(posedge CLK); #1;
    end
    $display("instr op=%07b cycles=%0d reset_abort=%0d", op, cycles, aborted);
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] op;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    ops[6] = 7'b1111111;

    RST = 1'b1; Opcode = 7'b0110011; Zero = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("init_state", State, 0);
    check_reset_outputs("init");
    @(posedge CLK); #1;
    RST = 1'b0;

    // Reset mid-ExecuteR.
    Opcode = 7'b0110011;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check("rstR_state_before", State, 6);
    check_reset_outputs("rstR");
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rstR_state_after", State, 0);
    check("rstR_irwrite", IRWrite, 1);
    check("rstR_pcwrite", PCWrite, 1);
    @(posedge CLK); #1;
    // That cycle was the Fetch of a new R instruction; let it finish.
    Opcode = 7'b0110011;
    @(negedge CLK);
    check("rstR_decode", State, 1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Directed pass over every class, beq with both Zero values.
    run_instr(7'b0000011, 2, 0);
    run_instr(7'b0100011, 2, 0);
    run_instr(7'b1100011, 1, 0);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b1101111, 2, 0);
    run_instr(7'b1111111, 2, 0);
    run_instr(7'b0110011, 2, 0);
    run_instr(7'b0010011, 2, 0);

    // Random instruction stream with occasional reset aborts.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else                           op = ops[$urandom_range(0, 6)];
      run_instr(op, 2, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
